// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//
// Streams a length-prefixed byte image into an instruction memory and then
// releases the CPU. The first accepted byte is the payload length N (0 means
// the full memory depth), the next N bytes are written to addresses 0..N-1,
// and every remaining address is written with FILL_VALUE. The CPU enable is
// raised only once the whole memory has been written.
//
// Optional feature (macro LOADER_CHECKSUM_EN):
//   When defined, one extra byte follows the payload and must equal the
//   modulo-256 sum of the payload bytes. A mismatch aborts the load into an
//   ERROR state (error high, no fill, CPU held off). When undefined, the
//   checksum byte, accumulator and ERROR state do not exist and error is 0.
//
// Parameters:
//   ADDR_WIDTH   instruction memory address width, depth = 2**ADDR_WIDTH
//   FILL_VALUE   word written to every address not covered by the payload
//
// Ports:
//   clock        system clock, all state changes on the rising edge
//   reset        asynchronous active-low reset
//   start        one-cycle request to begin a load (IDLE/DONE/ERROR only)
//   in_valid     byte-stream valid
//   in_data      byte-stream payload
//   in_ready     loader accepts a byte this cycle
//   mem_write    instruction memory write strobe (registered)
//   mem_address  write address (registered)
//   mem_data     write data (registered)
//   cpu_enable   high after a complete, valid load
//   busy         load or fill in progress
//   error        checksum mismatch, sticky until next start or reset
//   count        payload words written in the current or last load
// ---------------------------------------------------------------------------
module program_loader #(
  parameter int         ADDR_WIDTH = 8,
  parameter logic [7:0] FILL_VALUE = 8'h00
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [7:0]            mem_data,
  output logic                  cpu_enable,
  output logic                  busy,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int CW = ADDR_WIDTH + 1;

  // Depth and last address carry one extra bit so that a full-depth load
  // (N = 2**ADDR_WIDTH) can be represented and counters never wrap.
  localparam logic [CW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [CW-1:0] LAST  = {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic [CW-1:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LENGTH = 3'd1,
    S_DATA   = 3'd2,
    S_FILL   = 3'd3,
    S_DONE   = 3'd4
`ifdef LOADER_CHECKSUM_EN
    ,
    S_CHECK  = 3'd5,
    S_ERROR  = 3'd6
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         len_q, len_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         fill_q, fill_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            data_q, data_d;
  logic [CW-1:0]         lenDecode;
  logic [CW-1:0]         countInc;
  logic                  accept;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            sum_q, sum_d;
`endif

  // A byte moves only on a valid/ready handshake; ready is a pure function
  // of the state so a stalled stream simply holds everything in place.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      S_LENGTH, S_DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
`endif
      S_FILL:  busy = 1'b1;
      default: begin
        in_ready = 1'b0;
        busy     = 1'b0;
      end
    endcase
  end

  assign accept     = in_valid && in_ready;
  assign cpu_enable = (state_q == S_DONE);
`ifdef LOADER_CHECKSUM_EN
  assign error      = (state_q == S_ERROR);
`else
  assign error      = 1'b0;
`endif

  assign mem_write   = write_q;
  assign mem_address = addr_q;
  assign mem_data    = data_q;
  assign count       = count_q;
  assign countInc    = count_q + ONE;

  // Length byte decode: zero selects the whole memory, and a length larger
  // than the memory (only possible for narrow address widths) is clamped so
  // no write can ever land beyond the last address.
  always_comb begin
    lenDecode = DEPTH;
    if (in_data != 8'd0 && 32'(in_data) <= 32'(DEPTH)) begin
      lenDecode = CW'(in_data);
    end
  end

  // Next-state and datapath control. Memory writes are produced here and
  // registered below, so each write appears exactly one cycle after the
  // edge that accepted its byte (or the FILL cycle that issued it).
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    fill_d  = fill_q;
    write_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LENGTH;
          count_d = '0;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = 8'd0;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_ERROR: begin
        if (start) begin
          state_d = S_LENGTH;
          count_d = '0;
          sum_d   = 8'd0;
        end
      end
`endif
      S_LENGTH: begin
        if (accept) begin
          len_d   = lenDecode;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          write_d = 1'b1;
          addr_d  = count_q[ADDR_WIDTH-1:0];
          data_d  = in_data;
          count_d = countInc;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = sum_q + in_data;
`endif
          if (countInc == len_q) begin
            fill_d = len_q;
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = (len_q == DEPTH) ? S_DONE : S_FILL;
`endif
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) begin
          if (in_data == sum_q) begin
            state_d = (len_q == DEPTH) ? S_DONE : S_FILL;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
`endif
      S_FILL: begin
        write_d = 1'b1;
        addr_d  = fill_q[ADDR_WIDTH-1:0];
        data_d  = FILL_VALUE;
        fill_d  = fill_q + ONE;
        if (fill_q == LAST) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops everything immediately so an
  // interrupted load can never leave the CPU enabled or a write pending.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      count_q <= '0;
      fill_q  <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= 8'd0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      fill_q  <= fill_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, instruction-memory address width; depth is 2**ADDR_WIDTH words.
REQ-002 Parameter FILL_VALUE, default 8'h00, word written to every unloaded address.
REQ-003 clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a load.
REQ-006 in_valid  input  1  byte-stream data valid.
REQ-007 in_data  input  8  byte-stream payload.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 mem_write  output  1  instruction-memory write strobe.
REQ-010 mem_address  output  ADDR_WIDTH  write address.
REQ-011 mem_data  output  8  write data.
REQ-012 cpu_enable  output  1  CPU enable; high only after a complete, valid load.
REQ-013 busy  output  1  load or fill in progress.
REQ-014 error  output  1  load aborted on checksum mismatch; sticky until next start or reset.
REQ-015 count  output  ADDR_WIDTH+1  payload words written in current or last load.

Function
REQ-016 States: IDLE, LENGTH, DATA, CHECK, FILL, DONE, ERROR.
REQ-017 Byte transfer occurs on a rising edge with in_valid and in_ready both high; in_ready high only in LENGTH, DATA, CHECK.
REQ-018 IDLE/DONE/ERROR + start -> LENGTH; count cleared, error cleared, cpu_enable low from the next cycle.
REQ-019 start in LENGTH, DATA, CHECK or FILL is ignored.
REQ-020 LENGTH: accepted byte N sets payload length; N=0 means full depth; -> DATA.
REQ-021 DATA: each accepted byte written to address count, then count increments; after the Nth byte -> CHECK (macro on) or FILL.
REQ-022 Write latency: mem_write, mem_address, mem_data registered, asserted exactly one cycle after the accepting edge, for one cycle.
REQ-023 FILL: one write of FILL_VALUE per cycle, addresses N through depth-1 ascending, no input consumed; skipped (direct -> DONE) when N equals depth.
REQ-024 DONE: cpu_enable high, busy low, mem_write low; held until start or reset.
REQ-025 Address counter never wraps: length is byte-limited, and no write issued beyond depth-1.
REQ-026 busy high in LENGTH, DATA, CHECK, FILL.
REQ-027 Stalls (in_valid low) hold state and outputs indefinitely; no timeout.

Reset
REQ-028 reset low forces IDLE immediately regardless of clock: cpu_enable 0, mem_write 0, mem_address 0, mem_data 0, in_ready 0, busy 0, error 0, count 0.
REQ-029 Reset mid-load abandons the load; partially written memory is not restored; cpu_enable stays low until a later complete load.

Configuration
REQ-030 Macro LOADER_CHECKSUM_EN defined: after payload the CHECK state accepts one byte; equal to the 8-bit modulo-256 sum of payload bytes -> FILL, otherwise -> ERROR (error 1, cpu_enable 0, no fill).
REQ-031 Macro undefined: CHECK state, checksum accumulator and ERROR state absent; error tied 0; DATA goes directly to FILL.

Verification
REQ-032 Load N=3, bytes 11,22,33 back-to-back, ADDR_WIDTH=8 -> writes 0:11,1:22,2:33 each one cycle after acceptance, then 253 FILL writes 3..255 of 00, cpu_enable high, count 3.
REQ-033 N=0, 256 bytes with random in_valid gaps -> 256 data writes, no FILL writes, count 256, cpu_enable high.
REQ-034 LOADER_CHECKSUM_EN, N=2, bytes F0,20, checksum 10 -> DONE; repeat with checksum 11 -> error 1, cpu_enable 0, no writes after address 1.
REQ-035 start pulsed during DATA -> ignored, load completes normally; start in DONE -> cpu_enable drops next cycle, new load begins.
REQ-036 reset asserted between clock edges mid-DATA -> all outputs reset values immediately, state IDLE, subsequent full load succeeds.
